// File: rtl/anemo_freq_ctrl.sv
// anemo_freq_ctrl: anemometer pulse counter with programmable gate window.
// Synchronises the raw pulse input, counts rising edges over GATE_CYCLES
// clocks (one-shot or continuous) and exposes the result on a 4-word
// Avalon-MM slave with sticky VALID/OVF flags and a level interrupt.
module anemo_freq_ctrl #(
  parameter int unsigned GATE_CYCLES = 50_000_000,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [1:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        in_freq_anemo,
  output logic        irq
);

  localparam int unsigned WIN_W = $clog2(GATE_CYCLES);
  localparam logic [WIN_W-1:0]     WIN_LAST = WIN_W'(GATE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_RESULT = 2'd2;
  localparam logic [1:0] A_GATE   = 2'd3;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_MEASURE = 1'b1
  } state_t;

  // Input path
  logic r_sync1;
  logic r_sync2;
  logic r_dly;
  logic w_edge;

  // FSM and counters
  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIN_W-1:0]     r_win;
  logic [WIN_W-1:0]     w_win_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic [CNT_WIDTH-1:0] w_cnt_inc;
  logic                 w_cnt_sat;
  logic                 w_done;
  logic                 w_ovf_set;

  // Register file
  logic                 r_cont;
  logic                 r_irq_en;
  logic                 r_valid;
  logic                 r_ovf;
  logic [CNT_WIDTH-1:0] r_result;
  logic                 r_irq;
  logic [31:0]          r_rdata;
  logic                 w_cont_nxt;
  logic                 w_irq_en_nxt;
  logic                 w_valid_nxt;
  logic                 w_ovf_nxt;
  logic [CNT_WIDTH-1:0] w_result_nxt;
  logic [31:0]          w_rdata;

  // Bus decode
  logic w_wr;
  logic w_ctrl_wr;
  logic w_stat_wr;
  logic w_start;
  logic w_stop;
  logic w_rd_result;
  logic w_valid_clr;
  logic w_ovf_clr;
  logic w_unused;

  assign w_wr        = chipselect & write;
  assign w_ctrl_wr   = w_wr & (address == A_CTRL);
  assign w_stat_wr   = w_wr & (address == A_STATUS);
  assign w_stop      = w_ctrl_wr & writedata[2];
  assign w_start     = w_ctrl_wr & writedata[0] & ~writedata[2];
  assign w_rd_result = chipselect & read & (address == A_RESULT);
  assign w_valid_clr = (w_stat_wr & writedata[1]) | w_rd_result;
  assign w_ovf_clr   = w_stat_wr & writedata[2];
  assign w_unused    = ^writedata[31:4];

  assign w_edge    = r_sync2 & ~r_dly;
  assign w_cnt_sat = (r_cnt == CNT_MAX);
  assign w_cnt_inc = (w_edge && !w_cnt_sat) ? r_cnt + CNT_WIDTH'(1) : r_cnt;

  assign readdata = r_rdata;
  assign irq      = r_irq;

  // Two-flop synchroniser plus delay flop for rising-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_dly   <= 1'b0;
    end else begin
      r_sync1 <= in_freq_anemo;
      r_sync2 <= r_sync1;
      r_dly   <= r_sync2;
    end
  end

  // FSM state and window/edge counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_win   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_win   <= w_win_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: STOP beats START, START restarts, final cycle closes window
  always_comb begin
    w_state_nxt = r_state;
    w_win_nxt   = r_win;
    w_cnt_nxt   = r_cnt;
    w_done      = 1'b0;
    w_ovf_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_MEASURE;
          w_win_nxt   = '0;
          w_cnt_nxt   = '0;
        end
      end
      S_MEASURE: begin
        if (w_stop) begin
          w_state_nxt = S_IDLE;
        end else if (w_start) begin
          w_win_nxt = '0;
          w_cnt_nxt = '0;
        end else begin
          w_ovf_set = w_edge & w_cnt_sat;
          if (r_win == WIN_LAST) begin
            w_done    = 1'b1;
            w_win_nxt = '0;
            w_cnt_nxt = '0;
            if (!r_cont) begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_win_nxt = r_win + WIN_W'(1);
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Control/status next values; a set beats a clear in the same cycle
  always_comb begin
    w_cont_nxt   = w_ctrl_wr ? writedata[1] : r_cont;
    w_irq_en_nxt = w_ctrl_wr ? writedata[3] : r_irq_en;
    w_valid_nxt  = w_done | (r_valid & ~w_valid_clr);
    w_ovf_nxt    = w_ovf_set | (r_ovf & ~w_ovf_clr);
    w_result_nxt = w_done ? w_cnt_inc : r_result;
  end

  // Read mux on the current address, registered every cycle
  always_comb begin
    w_rdata = '0;
    case (address)
      A_CTRL: begin
        w_rdata[1] = r_cont;
        w_rdata[3] = r_irq_en;
      end
      A_STATUS: begin
        w_rdata[0] = (r_state == S_MEASURE);
        w_rdata[1] = r_valid;
        w_rdata[2] = r_ovf;
      end
      A_RESULT: w_rdata = 32'(r_result);
      A_GATE:   w_rdata = 32'(GATE_CYCLES);
      default:  w_rdata = '0;
    endcase
  end

  // Register file, read data and interrupt
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cont   <= 1'b0;
      r_irq_en <= 1'b0;
      r_valid  <= 1'b0;
      r_ovf    <= 1'b0;
      r_result <= '0;
      r_rdata  <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_cont   <= w_cont_nxt;
      r_irq_en <= w_irq_en_nxt;
      r_valid  <= w_valid_nxt;
      r_ovf    <= w_ovf_nxt;
      r_result <= w_result_nxt;
      r_rdata  <= w_rdata;
      r_irq    <= w_valid_nxt & w_irq_en_nxt;
    end
  end

endmodule

// File: tb/tb_anemo_freq_ctrl.sv
// Bench for anemo_freq_ctrl: a 16-bit and a 3-bit counter instance share the
// same stimulus and are checked every cycle against an integer-count model,
// plus directed scenario checks against fixed expected values.
module tb_anemo_freq_ctrl;

  localparam int unsigned G = 100;

  logic        clk;
  logic        reset;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [1:0]  address;
  logic [31:0] writedata;
  logic        in_freq_anemo;
  logic [31:0] rd16;
  logic [31:0] rd3;
  logic        irq16;
  logic        irq3;

  int n_cmp = 0;
  int n_err = 0;

  anemo_freq_ctrl #(.GATE_CYCLES(G), .CNT_WIDTH(16)) u_dut16 (
    .clk(clk), .reset(reset), .chipselect(chipselect), .read(read),
    .write(write), .address(address), .writedata(writedata),
    .readdata(rd16), .in_freq_anemo(in_freq_anemo), .irq(irq16)
  );

  anemo_freq_ctrl #(.GATE_CYCLES(G), .CNT_WIDTH(3)) u_dut3 (
    .clk(clk), .reset(reset), .chipselect(chipselect), .read(read),
    .write(write), .address(address), .writedata(writedata),
    .readdata(rd3), .in_freq_anemo(in_freq_anemo), .irq(irq3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Pulse generator: 0 = low, 1 = square wave of gen_per cycles, 2 = random
  int gen_mode = 0;
  int gen_per  = 10;
  int gen_ph   = 0;
  initial begin
    in_freq_anemo = 1'b0;
    forever begin
      @(negedge clk);
      case (gen_mode)
        1: begin
          if (gen_ph >= gen_per) gen_ph = 0;
          in_freq_anemo = (gen_ph < gen_per / 2);
          gen_ph = gen_ph + 1;
        end
        2:       in_freq_anemo = 1'($urandom_range(0, 1));
        default: in_freq_anemo = 1'b0;
      endcase
    end
  end

  // Reference model: raw integer edge counts, saturation applied on output
  bit          hist [0:32767];
  int          cyc = 0;
  bit          m_busy, m_valid, m_ovf16, m_ovf3, m_cont, m_irq_en, exp_irq;
  int          m_win, m_raw, m_res;
  logic [31:0] exp_rd16, exp_rd3;
  bit          t_pulse, t_wr, t_start, t_stop, t_done, t_set16, t_set3;

  function automatic logic [31:0] model_read(input logic [1:0] a, input int maxv, input bit ovf);
    logic [31:0] v;
    case (a)
      2'd0:    v = {28'd0, m_irq_en, 1'b0, m_cont, 1'b0};
      2'd1:    v = {29'd0, ovf, m_valid, m_busy};
      2'd2:    v = 32'((m_res > maxv) ? maxv : m_res);
      default: v = G;
    endcase
    return v;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 0; m_valid = 0; m_ovf16 = 0; m_ovf3 = 0; m_cont = 0; m_irq_en = 0;
      m_win = 0; m_raw = 0; m_res = 0;
      exp_rd16 = '0; exp_rd3 = '0; exp_irq = 0;
      hist[cyc] = 0;
      if (cyc >= 1) hist[cyc-1] = 0;
      if (cyc >= 2) hist[cyc-2] = 0;
    end else begin
      hist[cyc] = in_freq_anemo;
      t_pulse  = (cyc >= 3) && hist[cyc-2] && !hist[cyc-3];
      exp_rd16 = model_read(address, 65535, m_ovf16);
      exp_rd3  = model_read(address, 7, m_ovf3);
      t_wr    = chipselect && write;
      t_start = t_wr && address == 2'd0 && writedata[0] && !writedata[2];
      t_stop  = t_wr && address == 2'd0 && writedata[2];
      t_done = 0; t_set16 = 0; t_set3 = 0;
      if (m_busy) begin
        if (t_stop) begin
          m_busy = 0;
        end else if (t_start) begin
          m_win = 0; m_raw = 0;
        end else begin
          if (t_pulse) begin
            m_raw++;
            t_set16 = (m_raw > 65535);
            t_set3  = (m_raw > 7);
          end
          if (m_win == G - 1) begin
            t_done = 1; m_res = m_raw; m_win = 0; m_raw = 0;
            if (!m_cont) m_busy = 0;
          end else begin
            m_win++;
          end
        end
      end else if (t_start) begin
        m_busy = 1; m_win = 0; m_raw = 0;
      end
      m_valid = t_done || (m_valid && !((t_wr && address == 2'd1 && writedata[1]) ||
                                         (chipselect && read && address == 2'd2)));
      m_ovf16 = t_set16 || (m_ovf16 && !(t_wr && address == 2'd1 && writedata[2]));
      m_ovf3  = t_set3  || (m_ovf3  && !(t_wr && address == 2'd1 && writedata[2]));
      if (t_wr && address == 2'd0) begin
        m_cont   = writedata[1];
        m_irq_en = writedata[3];
      end
      exp_irq = m_valid && m_irq_en;
    end
    cyc++;
    #1;
    chk("model_rd16", rd16, exp_rd16);
    chk("model_rd3", rd3, exp_rd3);
    chk("model_irq16", 32'(irq16), 32'(exp_irq));
    chk("model_irq3", 32'(irq3), 32'(exp_irq));
  end

  // Bus helpers: entered and left on a falling edge
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] v16, output logic [31:0] v3);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    v16 = rd16; v3 = rd3;
  endtask

  task automatic wait_bit(input int b, input logic lvl, input int bound, input string tag,
                          output int ncyc);
    bit found = 0;
    address = 2'd1;
    ncyc = bound;
    for (int k = 1; k <= bound; k++) begin
      @(negedge clk);
      if (rd16[b] == lvl) begin
        found = 1; ncyc = k - 1;
        break;
      end
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  logic [31:0] v16, v3;
  int n, sum;

  initial begin
    reset = 1'b1; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    address = 2'd0; writedata = '0;

    // Reset with random bus activity
    for (int i = 0; i < 3; i++) begin
      chipselect = 1'($urandom_range(0, 1)); read = 1'($urandom_range(0, 1));
      write = 1'($urandom_range(0, 1)); address = 2'($urandom_range(0, 3));
      writedata = $urandom;
      @(negedge clk);
    end
    chk("reset_rd16", rd16, 32'd0);
    chk("reset_irq16", 32'(irq16), 32'd0);
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
    reset = 1'b0;
    idle(2);
    bus_read(2'd1, v16, v3); chk("reset_status", v16, 32'd0);
    bus_read(2'd2, v16, v3); chk("reset_result", v16, 32'd0);
    bus_read(2'd3, v16, v3); chk("gate_reg", v16, 32'd100);

    // One-shot, period 10
    gen_per = 10; gen_mode = 1; idle(20);
    bus_write(2'd0, 32'h9);
    wait_bit(0, 1'b0, 250, "oneshot_wait", n);
    chk("oneshot_busy_cycles", n, 32'd100);
    chk("oneshot_status16", rd16, 32'h2);
    chk("oneshot_status3", rd3, 32'h6);
    chk("oneshot_irq16", 32'(irq16), 32'd1);
    bus_read(2'd2, v16, v3);
    chk("oneshot_result16", v16, 32'd10);
    chk("oneshot_result3", v3, 32'd7);
    chk("oneshot_irq_clr", 32'(irq16), 32'd0);
    bus_write(2'd1, 32'h4);

    // Continuous, period 20
    gen_per = 20; idle(40);
    bus_write(2'd0, 32'h3);
    sum = 0;
    for (int w = 0; w < 5; w++) begin
      wait_bit(1, 1'b1, 250, "cont_wait", n);
      bus_read(2'd2, v16, v3);
      chk("cont_result16", v16, 32'd5);
      chk("cont_result3", v3, 32'd5);
      sum += int'(v16);
    end
    chk("cont_sum", sum, 32'd25);
    bus_write(2'd0, 32'h0);
    wait_bit(0, 1'b0, 250, "cont_end_wait", n);
    chk("cont_end_status", rd16, 32'h2);
    bus_read(2'd2, v16, v3);
    chk("cont_end_result", v16, 32'd5);

    // Saturation, period 4
    gen_per = 4; idle(20);
    bus_write(2'd0, 32'h1);
    wait_bit(0, 1'b0, 250, "sat_wait", n);
    chk("sat_status16", rd16, 32'h2);
    chk("sat_status3", rd3, 32'h6);
    bus_read(2'd2, v16, v3);
    chk("sat_result16", v16, 32'd25);
    chk("sat_result3", v3, 32'd7);
    bus_write(2'd1, 32'h4);
    bus_read(2'd1, v16, v3);
    chk("sat_ovf_clr", v3, 32'h0);

    // Stop mid-window, then START+STOP together
    gen_per = 10; idle(20);
    bus_write(2'd0, 32'h1);
    idle(50);
    bus_write(2'd0, 32'h4);
    address = 2'd1;
    @(negedge clk);
    chk("stop_status", rd16, 32'h0);
    bus_read(2'd2, v16, v3);
    chk("stop_result16", v16, 32'd25);
    chk("stop_result3", v3, 32'd7);
    bus_write(2'd0, 32'h5);
    address = 2'd1;
    idle(3);
    chk("startstop_idle", rd16, 32'h0);

    // Result read on the completing cycle: set wins
    bus_write(2'd0, 32'h9);
    idle(99);
    bus_read(2'd2, v16, v3);
    chk("race_old_result", v16, 32'd25);
    address = 2'd1;
    @(negedge clk);
    chk("race_status16", rd16, 32'h2);
    chk("race_status3", rd3, 32'h6);
    chk("race_irq", 32'(irq16), 32'd1);
    bus_read(2'd2, v16, v3);
    chk("race_result", v16, 32'd10);

    // Reset mid-window
    bus_write(2'd1, 32'h6);
    bus_write(2'd0, 32'h9);
    idle(60);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    chk("rst_mid_irq", 32'(irq16), 32'd0);
    bus_read(2'd0, v16, v3); chk("rst_mid_ctrl", v16, 32'd0);
    bus_read(2'd1, v16, v3); chk("rst_mid_status", v16, 32'd0);
    bus_read(2'd2, v16, v3); chk("rst_mid_result", v16, 32'd0);
    address = 2'd1;
    idle(150);
    chk("rst_mid_no_valid", rd16, 32'd0);
    chk("rst_mid_no_irq", 32'(irq16), 32'd0);

    // Randomized traffic, checked by the model each cycle
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 9))
        0, 1: bus_write(2'd0, 32'($urandom_range(0, 15)));
        2:    bus_write(2'd1, 32'($urandom_range(0, 7)));
        3:    bus_write(2'($urandom_range(2, 3)), $urandom);
        4, 5: bus_read(2'($urandom_range(0, 3)), v16, v3);
        6: begin
          gen_per  = $urandom_range(2, 24);
          gen_mode = $urandom_range(1, 2);
        end
        default: begin
          address = 2'($urandom_range(0, 3));
          idle($urandom_range(10, 120));
        end
      endcase
    end
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
